// File: rtl/iob_pfsm_loader.sv
// Streams a PFSM program into an iob_pfsm over its IOb CSR bus: assert soft reset, write every
// LUT word through MEM_WORD_SELECT/MEMORY, release soft reset, then pulse done (err on abort).
module iob_pfsm_loader #(
  parameter int unsigned DATA_W               = 32,
  parameter int unsigned ADDR_W               = 16,
  parameter int unsigned STATE_W              = 2,
  parameter int unsigned INPUT_W              = 1,
  parameter int unsigned OUTPUT_W             = 1,
  parameter int unsigned SOFTRESET_ADDR       = 0,
  parameter int unsigned MEM_WORD_SELECT_ADDR = 4,
  parameter int unsigned MEMORY_ADDR          = 256
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                ld_valid_i,
  input  logic [DATA_W-1:0]   ld_data_i,
  output logic                ld_ready_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int unsigned EntryW     = STATE_W + INPUT_W;
  localparam int unsigned NWords     = (STATE_W + OUTPUT_W + DATA_W - 1) / DATA_W;
  localparam int unsigned WordW      = (NWords > 1) ? $clog2(NWords) : 1;
  localparam int unsigned EntryShift = $clog2(DATA_W / 8);
  localparam int unsigned StrbW      = DATA_W / 8;
  localparam logic [WordW-1:0] WordLast = WordW'(NWords - 1);

  typedef enum logic [2:0] {
    StIdle, StSrstSet, StFetch, StSel, StWmem, StSrstClr, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [EntryW-1:0]   entry_q, entry_d;
  logic [WordW-1:0]    word_q, word_d;
  logic [WordW-1:0]    sel_q, sel_d;
  logic                sel_vld_q, sel_vld_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                abort_q, abort_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic                ld_ready_q, ld_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic ld_hs, wr_hs, abort_req, last_word, last_entry, need_sel;

  assign ld_hs      = ld_ready_q & ld_valid_i;
  assign wr_hs      = valid_q & iob_ready_i;
  assign abort_req  = abort_q | abort_i;
  assign last_word  = (word_q == WordLast);
  assign last_entry = &entry_q;
  assign need_sel   = !sel_vld_q || (sel_q != word_q);

  // Write states spend one cycle with valid low after the handshake before moving on.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_i) state_d = StSrstSet;
      StSrstSet: if (!valid_q) state_d = StFetch;
      StFetch: begin
        if (abort_req)  state_d = StSrstClr;
        else if (ld_hs) state_d = need_sel ? StSel : StWmem;
      end
      StSel:     if (!valid_q) state_d = abort_req ? StSrstClr : StWmem;
      StWmem: begin
        if (!valid_q) state_d = (abort_req || (last_entry && last_word)) ? StSrstClr : StFetch;
      end
      StSrstClr: if (!valid_q) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    entry_d   = entry_q;
    word_d    = word_q;
    sel_d     = sel_q;
    sel_vld_d = sel_vld_q;
    data_d    = data_q;
    abort_d   = abort_q;
    valid_d   = valid_q & ~iob_ready_i;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          entry_d = '0;
          word_d  = '0;
          abort_d = 1'b0;
        end
      end
      StSrstSet: sel_vld_d = 1'b0;
      StFetch: begin
        abort_d = abort_req;
        if (ld_hs) data_d = ld_data_i;
      end
      StSel: begin
        abort_d = abort_req;
        if (wr_hs) begin
          sel_d     = word_q;
          sel_vld_d = 1'b1;
        end
      end
      StWmem: begin
        abort_d = abort_req;
        if (!valid_q) begin
          if (last_word) begin
            word_d  = '0;
            entry_d = entry_q + 1'b1;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Registered outputs: load the request for the state being entered.
    if (state_d != state_q) begin
      unique case (state_d)
        StSrstSet: begin
          valid_d = 1'b1;
          addr_d  = ADDR_W'(SOFTRESET_ADDR);
          wdata_d = DATA_W'(1);
        end
        StSel: begin
          valid_d = 1'b1;
          addr_d  = ADDR_W'(MEM_WORD_SELECT_ADDR);
          wdata_d = DATA_W'(word_q);
        end
        StWmem: begin
          valid_d = 1'b1;
          addr_d  = ADDR_W'(MEMORY_ADDR) + (ADDR_W'(entry_q) << EntryShift);
          wdata_d = data_d;
        end
        StSrstClr: begin
          valid_d = 1'b1;
          addr_d  = ADDR_W'(SOFTRESET_ADDR);
          wdata_d = '0;
        end
        default: ;
      endcase
    end

    wstrb_d    = {StrbW{valid_d}};
    ld_ready_d = (state_d == StFetch);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    err_d      = (state_d == StDone) & abort_d;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StIdle;
    end else if (cke_i) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      entry_q    <= '0;
      word_q     <= '0;
      sel_q      <= '0;
      sel_vld_q  <= 1'b0;
      data_q     <= '0;
      abort_q    <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (cke_i) begin
      entry_q    <= entry_d;
      word_q     <= word_d;
      sel_q      <= sel_d;
      sel_vld_q  <= sel_vld_d;
      data_q     <= data_d;
      abort_q    <= abort_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ld_ready_o  = ld_ready_q;
  assign iob_valid_o = valid_q;
  assign iob_addr_o  = addr_q;
  assign iob_wdata_o = wdata_q;
  assign iob_wstrb_o = wstrb_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_iob_pfsm_loader.sv
// Scoreboard bench for iob_pfsm_loader: two words per LUT entry, random data, backpressure,
// stream gaps, abort, reset mid-load and ignored start/abort inputs.
module tb_iob_pfsm_loader;

  localparam int NE = 8;  // 2^(STATE_W+INPUT_W)
  localparam int NW = 2;  // ceil((2+40)/32)

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        cke_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        ld_valid_i = 1'b0;
  logic [31:0] ld_data_i = '0;
  logic        ld_ready_o;
  logic        iob_valid_o;
  logic [15:0] iob_addr_o;
  logic [31:0] iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic        iob_ready_i = 1'b1;
  logic        busy_o, done_o, err_o;

  iob_pfsm_loader #(
    .DATA_W(32), .ADDR_W(16), .STATE_W(2), .INPUT_W(1), .OUTPUT_W(40),
    .SOFTRESET_ADDR(0), .MEM_WORD_SELECT_ADDR(4), .MEMORY_ADDR(256)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .cke_i(cke_i), .start_i(start_i), .abort_i(abort_i),
    .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard queues filled by the reference model.
  wr_t         exp_wr[$];
  bit          exp_done[$];
  logic [31:0] stream[16];
  int          exp_nsel;

  function automatic wr_t mk(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = 16'(a);
    w.data = d;
    return w;
  endfunction

  // Expected bus traffic when the first k stream words get written.
  task automatic push_load(input int k, input bit err);
    int  last_w;
    bit  lv;
    lv = 1'b0;
    last_w = 0;
    exp_nsel = 0;
    exp_wr.push_back(mk(0, 32'd1));
    for (int i = 0; i < k; i++) begin
      int e, w;
      e = i / NW;
      w = i % NW;
      if (!lv || last_w != w) begin
        exp_wr.push_back(mk(4, 32'(w)));
        exp_nsel++;
        lv = 1'b1;
        last_w = w;
      end
      exp_wr.push_back(mk(256 + e * 4, stream[i]));
    end
    exp_wr.push_back(mk(0, 32'd0));
    exp_done.push_back(err);
  endtask

  // Monitor: everything sampled on the falling edge.
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          watch_ready = 1'b0;
  int          ready_after_abort = 0;
  bit          pv = 1'b0, phs = 1'b0;
  logic [15:0] paddr;
  logic [31:0] pdata;

  always @(negedge clk) begin
    if (!arst_n_i) begin
      pv = 1'b0;
      phs = 1'b0;
    end else begin
      chk("wstrb", 64'(iob_wstrb_o), iob_valid_o ? 64'hf : 64'h0);
      if (iob_valid_o && pv && !phs) begin
        chk("addr_stable", 64'(iob_addr_o), 64'(paddr));
        chk("wdata_stable", 64'(iob_wdata_o), 64'(pdata));
      end
      if (iob_valid_o && iob_ready_i) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {16'h0, iob_addr_o, iob_wdata_o}, 64'hffff_ffff_ffff_ffff);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(iob_addr_o), 64'(e.addr));
          chk("wr_data", 64'(iob_wdata_o), 64'(e.data));
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_done.size() == 0) chk("unexpected_done", 64'(done_o), 64'h0);
        else chk("done_err", 64'(err_o), 64'(exp_done.pop_front()));
      end else begin
        chk("err_without_done", 64'(err_o), 64'h0);
      end
      if (watch_ready && ld_ready_o) ready_after_abort++;
      pv = iob_valid_o;
      phs = iob_valid_o && iob_ready_i;
      paddr = iob_addr_o;
      pdata = iob_wdata_o;
    end
  end

  // IOb slave ready policy.
  int          bp_mode = 0;
  int          bp_cnt = 0;
  bit          hold_en = 1'b0;
  logic [15:0] hold_addr = '0;

  always @(posedge clk) begin
    #1;
    if (hold_en && iob_valid_o && iob_addr_o == hold_addr) begin
      iob_ready_i = 1'b0;
    end else begin
      case (bp_mode)
        0: iob_ready_i = 1'b1;
        1: begin
          if (iob_valid_o) begin
            if (bp_cnt < 3) begin
              iob_ready_i = 1'b0;
              bp_cnt++;
            end else begin
              iob_ready_i = 1'b1;
            end
          end else begin
            bp_cnt = 0;
            iob_ready_i = 1'b0;
          end
        end
        default: iob_ready_i = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Program-word source.
  logic [31:0] feed_q[$];
  int          gap_mode = 0;
  int          gap_cnt = 0;
  int          flush_req = 0, flush_ack = 0;
  bit          hs_seen = 1'b0;

  always @(negedge clk) hs_seen = ld_valid_i && ld_ready_o;

  function automatic int gap_len();
    if (gap_mode == 0) return 0;
    if (gap_mode == 1) return 5;
    return int'($urandom_range(0, 4));
  endfunction

  always @(posedge clk) begin
    #1;
    if (flush_ack != flush_req) begin
      flush_ack = flush_req;
      feed_q.delete();
      ld_valid_i = 1'b0;
      gap_cnt = 0;
    end else if (hs_seen) begin
      void'(feed_q.pop_front());
      ld_valid_i = 1'b0;
      gap_cnt = gap_len();
      if (gap_cnt == 0 && feed_q.size() > 0) begin
        ld_valid_i = 1'b1;
        ld_data_i = feed_q[0];
      end
    end else if (!ld_valid_i) begin
      if (gap_cnt > 0) gap_cnt--;
      else if (feed_q.size() > 0) begin
        ld_valid_i = 1'b1;
        ld_data_i = feed_q[0];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_all();
    flush_req++;
    @(posedge clk);
    #2;
  endtask

  task automatic new_stream();
    for (int i = 0; i < 16; i++) begin
      stream[i] = $urandom;
      feed_q.push_back(stream[i]);
    end
  endtask

  task automatic do_start(output int t0);
    tick();
    start_i = 1'b1;
    t0 = cyc;
    tick();
    start_i = 1'b0;
    @(negedge clk);
    chk("busy_at_t1", 64'(busy_o), 64'h1);
    chk("srst_valid_at_t1", {31'h0, iob_valid_o, iob_addr_o, iob_wdata_o[15:0]}, 64'h1_0000_0001);
  endtask

  task automatic wait_done(input int target, input int bound, input bit junk, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      start_i = junk && (i % 7 == 3);
    end
    start_i = 1'b0;
    chk("done_seen", 64'(ok), 64'h1);
  endtask

  task automatic run_full(input int bpm, input int gm, input bit junk);
    int t0, target;
    bit ok;
    bp_mode = bpm;
    gap_mode = gm;
    new_stream();
    push_load(16, 1'b0);
    target = done_cnt + 1;
    do_start(t0);
    wait_done(target, 5000, junk, ok);
    if (ok) begin
      if (bpm == 0 && gm == 0)
        chk("latency", 64'(done_cyc - t0), 64'(2 * (2 + NE * NW + exp_nsel) + NE * NW + 1));
      chk("busy_at_done", 64'(busy_o), 64'h1);
      @(negedge clk);
      chk("busy_after_done", 64'(busy_o), 64'h0);
    end
    chk("writes_outstanding", 64'(exp_wr.size()), 64'h0);
    flush_all();
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk(nm, {iob_valid_o, ld_ready_o, busy_o, done_o, err_o, iob_wstrb_o, iob_addr_o,
             iob_wdata_o}, 64'h0);
  endtask

  initial begin
    int  t0, target;
    bit  ok, found;

    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    arst_n_i = 1'b1;

    // abort in IDLE must be ignored, then an ideal load
    tick();
    abort_i = 1'b1;
    tick();
    tick();
    abort_i = 1'b0;
    repeat (2) tick();
    run_full(0, 0, 1'b0);

    // backpressure, 5-cycle stream gaps, start pulses while busy
    run_full(1, 1, 1'b1);

    // random ready and gaps
    for (int r = 0; r < 2; r++) run_full(2, 2, 1'b1);

    // abort while entry 3's first memory write is held
    bp_mode = 0;
    gap_mode = 0;
    new_stream();
    push_load(7, 1'b1);
    hold_addr = 16'd268;
    hold_en = 1'b1;
    ready_after_abort = 0;
    target = done_cnt + 1;
    do_start(t0);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      found = iob_valid_o && iob_addr_o == 16'd268;
    end
    chk("abort_target_reached", 64'(found), 64'h1);
    tick();
    abort_i = 1'b1;
    watch_ready = 1'b1;
    tick();
    tick();
    abort_i = 1'b0;
    hold_en = 1'b0;
    wait_done(target, 500, 1'b0, ok);
    chk("ld_ready_after_abort", 64'(ready_after_abort), 64'h0);
    chk("abort_writes_outstanding", 64'(exp_wr.size()), 64'h0);
    watch_ready = 1'b0;
    flush_all();

    // reset while the second select write is pending
    bp_mode = 1;
    gap_mode = 0;
    new_stream();
    push_load(16, 1'b0);
    do_start(t0);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      found = iob_valid_o && iob_addr_o == 16'd4 && iob_wdata_o == 32'd1;
    end
    chk("sel_target_reached", 64'(found), 64'h1);
    arst_n_i = 1'b0;
    #1;
    chk_outputs_zero("outputs_in_reset");
    exp_wr.delete();
    exp_done.delete();
    flush_all();
    @(negedge clk);
    arst_n_i = 1'b1;
    run_full(0, 0, 1'b0);

    repeat (5) @(negedge clk);
    chk("spurious_writes_at_end", 64'(exp_done.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
